// File: rtl/byte_lane_packer_if.sv
// byte_lane_packer_if: byte stream in, packed word/mask out.
// Valid/ready on both sides; slave = packer, master = its peer.
interface byte_lane_packer_if #(
  parameter int NBYTES = 4
);
  logic [7:0]              in_data;
  logic                    in_valid;
  logic                    in_last;
  logic                    in_ready;
  logic [0:NBYTES-1][7:0]  out_data;
  logic [0:NBYTES-1]       out_mask;
  logic                    out_last;
  logic                    out_valid;
  logic                    out_ready;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_mask, out_last, out_valid
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_mask, out_last, out_valid
  );
endinterface

// File: rtl/byte_lane_packer.sv
// byte_lane_packer: packs bytes into NBYTES-lane words + fill mask.
// Optional macro BYTE_LANE_PACKER_DOUBLE_BUFFER_EN overlaps fill/hold.
module byte_lane_packer #(
  parameter int NBYTES = 4,
  parameter int CNT_W  = $clog2(NBYTES)
) (
  input logic                clock,
  input logic                reset,
  byte_lane_packer_if.slave  bus
);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        idx_q, idx_d;
  logic [0:NBYTES-1][7:0]  acc_q, acc_d;
  logic [0:NBYTES-1]       accm_q, accm_d;
  logic [0:NBYTES-1][7:0]  word_q, word_d;
  logic [0:NBYTES-1]       mask_q, mask_d;
  logic                    last_q, last_d;
  logic [0:NBYTES-1][7:0]  ld_data;
  logic [0:NBYTES-1]       ld_mask;
  logic                    in_ready;
  logic                    out_valid;
  logic                    at_end;
  logic                    in_xfer;
  logic                    out_xfer;
  logic                    complete;

  assign at_end   = (idx_q == CNT_W'(NBYTES - 1));
  assign in_xfer  = bus.in_valid && in_ready;
  assign out_xfer = out_valid && bus.out_ready;
  assign complete = in_xfer && (at_end || bus.in_last);

  // State register: HOLD means the output register owns a word.
  always_ff @(posedge clock) begin
    if (reset) state_q <= FILL;
    else       state_q <= state_d;
  end

  // Next state: a completed word always lands in HOLD, even on drain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: if (complete) state_d = HOLD;
      HOLD: begin
        if (complete)      state_d = HOLD;
        else if (out_xfer) state_d = FILL;
      end
    endcase
  end

  // Handshake outputs derived from state.
  always_comb begin
    out_valid = (state_q == HOLD);
`ifdef BYTE_LANE_PACKER_DOUBLE_BUFFER_EN
    in_ready  = !(out_valid && !bus.out_ready
                  && (at_end || bus.in_last));
`else
    in_ready  = (state_q == FILL);
`endif
  end

  // Datapath next-state: accumulate lanes, hand off on completion.
  always_comb begin
    ld_data          = acc_q;
    ld_data[idx_q]   = bus.in_data;
    ld_mask          = accm_q;
    ld_mask[idx_q]   = 1'b1;
    acc_d            = acc_q;
    accm_d           = accm_q;
    idx_d            = idx_q;
    word_d           = word_q;
    mask_d           = mask_q;
    last_d           = last_q;
    if (in_xfer) begin
      if (complete) begin
        acc_d  = '0;
        accm_d = '0;
        idx_d  = '0;
      end else begin
        acc_d  = ld_data;
        accm_d = ld_mask;
        idx_d  = idx_q + 1'b1;
      end
    end
    if (complete) begin
      word_d = ld_data;
      mask_d = ld_mask;
      last_d = bus.in_last;
    end else if (out_xfer) begin
      word_d = '0;
      mask_d = '0;
      last_d = 1'b0;
    end
  end

  // Datapath registers; reset discards partial and pending words.
  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q  <= '0;
      acc_q  <= '0;
      accm_q <= '0;
      word_q <= '0;
      mask_q <= '0;
      last_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      acc_q  <= acc_d;
      accm_q <= accm_d;
      word_q <= word_d;
      mask_q <= mask_d;
      last_q <= last_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = word_q;
  assign bus.out_mask  = mask_q;
  assign bus.out_last  = last_q;

endmodule

// File: tb/tb_byte_lane_packer.sv
// tb_byte_lane_packer: directed vector table plus corner sequences.
// Build with BYTE_LANE_PACKER_DOUBLE_BUFFER_EN to check overlap mode.
module tb_byte_lane_packer;
  localparam int NB = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  byte_lane_packer_if #(.NBYTES(NB)) bus ();

  byte_lane_packer #(.NBYTES(NB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef BYTE_LANE_PACKER_DOUBLE_BUFFER_EN
  localparam logic HOLD_RDY = 1'b1;
`else
  localparam logic HOLD_RDY = 1'b0;
`endif

  typedef struct {
    int          n;
    logic [31:0] bytes;
    logic        last;
    logic [31:0] exp_data;
    logic [3:0]  exp_mask;
    logic        exp_last;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input int n, input logic [31:0] b,
                      input logic last);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = b[31-8*i -: 8];
      bus.in_last  = last && (i == n - 1);
      chk("in_ready_fill", 32'(bus.in_ready), 32'd1);
      step();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  task automatic chk_word(input string nm, input logic [31:0] d,
                          input logic [3:0] m, input logic l);
    chk({nm, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({nm, "_data"},  32'(bus.out_data), d);
    chk({nm, "_mask"},  32'(bus.out_mask), 32'(m));
    chk({nm, "_last"},  32'(bus.out_last), 32'(l));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    vecs[0] = '{4, 32'h11223344, 1'b0, 32'h11223344, 4'b1111, 1'b0};
    vecs[1] = '{2, 32'hAABB0000, 1'b1, 32'hAABB0000, 4'b1100, 1'b1};
    vecs[2] = '{1, 32'h5A000000, 1'b1, 32'h5A000000, 4'b1000, 1'b1};
    vecs[3] = '{4, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 4'b1111, 1'b1};
    vecs[4] = '{3, 32'h01020300, 1'b1, 32'h01020300, 4'b1110, 1'b1};

    step();
    step();
    reset = 1'b0;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data",  32'(bus.out_data), 32'd0);
    chk("rst_mask",  32'(bus.out_mask), 32'd0);
    chk("rst_last",  32'(bus.out_last), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);

    for (int v = 0; v < 5; v++) begin
      send(vecs[v].n, vecs[v].bytes, vecs[v].last);
      chk_word($sformatf("vec%0d", v), vecs[v].exp_data,
               vecs[v].exp_mask, vecs[v].exp_last);
      chk($sformatf("vec%0d_hold_rdy", v),
          32'(bus.in_ready), 32'(HOLD_RDY));
      step();
      chk($sformatf("vec%0d_drop", v), 32'(bus.out_valid), 32'd0);
      chk($sformatf("vec%0d_clr", v),  32'(bus.out_mask), 32'd0);
      chk($sformatf("vec%0d_clrd", v), 32'(bus.out_data), 32'd0);
    end

    // Idle cycles with junk on data/last must not disturb the fill.
    send(1, 32'h10000000, 1'b0);
    bus.in_data = 8'hEE;
    bus.in_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("idle_valid", 32'(bus.out_valid), 32'd0);
    end
    bus.in_last = 1'b0;
    send(3, 32'h20304000, 1'b0);
    chk_word("gap", 32'h10203040, 4'b1111, 1'b0);
    step();

    // Backpressure: output must hold for 5 cycles.
    bus.out_ready = 1'b0;
    send(4, 32'hCAFEF00D, 1'b0);
    for (int k = 0; k < 5; k++) begin
`ifndef BYTE_LANE_PACKER_DOUBLE_BUFFER_EN
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hFF;
      bus.in_last  = 1'b1;
`endif
      chk_word("stall", 32'hCAFEF00D, 4'b1111, 1'b0);
      chk("stall_rdy", 32'(bus.in_ready), 32'(HOLD_RDY));
      step();
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    chk_word("stall_end", 32'hCAFEF00D, 4'b1111, 1'b0);
    step();
    chk("release_valid", 32'(bus.out_valid), 32'd0);
    chk("release_rdy",   32'(bus.in_ready), 32'd1);
    send(2, 32'h12340000, 1'b1);
    chk_word("post_stall", 32'h12340000, 4'b1100, 1'b1);
    step();

    // Reset mid-word discards the partial bytes.
    send(2, 32'h99880000, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    send(4, 32'h01020304, 1'b0);
    chk_word("rst_mid", 32'h01020304, 4'b1111, 1'b0);
    step();

    // Reset while a word is pending drops it.
    bus.out_ready = 1'b0;
    send(4, 32'hA1B2C3D4, 1'b0);
    chk("pend_valid", 32'(bus.out_valid), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("pend_drop",  32'(bus.out_valid), 32'd0);
    chk("pend_data",  32'(bus.out_data), 32'd0);
    chk("pend_rdy",   32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;

`ifdef BYTE_LANE_PACKER_DOUBLE_BUFFER_EN
    // Back-to-back words every NB cycles with no input stall.
    for (int i = 0; i < 12; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i + 1);
      bus.in_last  = 1'b0;
      chk("db_rdy", 32'(bus.in_ready), 32'd1);
      step();
      if (i % 4 == 3) begin
        chk_word("db", {8'(i - 2), 8'(i - 1), 8'(i), 8'(i + 1)},
                 4'b1111, 1'b0);
      end else begin
        chk("db_gap", 32'(bus.out_valid), 32'd0);
      end
    end
    bus.in_valid = 1'b0;
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/byte_lane_packer.md
Name: byte_lane_packer

Overview:
- Serial-to-parallel packing stage that collects a stream of bytes into one packed word `[0:NBYTES-1][7:0]` plus a per-lane fill mask `[0:NBYTES-1]`.
- Sits directly upstream of the concatenation/slicing stage, which consumes `{word, mask}`.
- Uses valid/ready handshakes on both sides.
- An early `in_last` flushes a partial word, with unfilled lanes zeroed and flagged in the mask.

Parameters:
- NBYTES, 4, number of byte lanes per output word (≥2).
- CNT_W, $clog2(NBYTES), width of the internal lane index.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- in_data  input  8  input byte.
- in_valid  input  1  in_data is valid this cycle.
- in_last  input  1  qualifies in_data as the final byte of a packet; forces word emission.
- in_ready  output  1  stage can accept a byte this cycle.
- out_data  output  [0:NBYTES-1][7:0]  packed word; lane 0 is the first byte received, at the MSB end.
- out_mask  output  [0:NBYTES-1]  1 = lane holds a received byte; bit 0 is the MSB.
- out_last  output  1  word closes a packet.
- out_valid  output  1  out_data/out_mask/out_last are valid.
- out_ready  input  1  downstream accepts the word.

Behaviour:
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - out_* must hold stable while out_valid && !out_ready.
- Reset values, applied on the synchronous clock edge with reset=1:
  - out_valid=0, out_data=0, out_mask=0, out_last=0, in_ready=1, lane index idx=0, state=FILL.
  - Reset mid-word discards partial data; reset while out_valid drops the word without a transfer.
- State FILL:
  - in_ready=1.
  - On transfer: accumulator lane[idx] <= in_data, mask[idx] <= 1.
  - If idx==NBYTES-1 or in_last:
    - Move the accumulated word (including this byte) to the output register.
    - Set out_valid=1 and out_last=in_last; unfilled lanes are 0 with mask 0.
    - Clear the accumulator and mask, set idx=0, go to HOLD.
  - Otherwise idx <= idx+1.
- State HOLD:
  - in_ready=0 (base build); out_valid=1.
  - On output transfer: out_valid <= 0, go to FILL.
  - in_ready returns to 1 on the following cycle.
- Latency: out_valid rises one cycle after the input transfer of the last lane or of in_last.
- Throughput: one word per NBYTES+1 cycles in the base build.
- Boundaries:
  - in_last on lane 0 emits mask 1000 (NBYTES=4).
  - in_last on lane NBYTES-1 emits a full word with out_last=1.
  - idx never exceeds NBYTES-1 and wraps to 0 only via emission.
  - in_valid=0 never alters state.
  - in_data and in_last are ignored when in_ready=0.
  - out_data/out_mask are cleared to 0 on output transfer only when the next word is not loaded in the same cycle.

Optional Feature:
- Macro: BYTE_LANE_PACKER_DOUBLE_BUFFER_EN.
- Defined:
  - The accumulator and output register are independent; in_ready stays 1 while the output holds a word, so the next word fills concurrently.
  - in_ready=0 only when the accumulator would complete a word while the output register is still occupied and not transferring that cycle.
  - A simultaneous output transfer and accumulator completion loads the new word, keeping out_valid=1 with no bubble.
  - Sustained throughput is one word per NBYTES cycles.
- Undefined: the FILL/HOLD behaviour above, with in_ready=0 throughout HOLD.

Test Plan:
- Reset, then bytes 0x11,0x22,0x33,0x44 on consecutive cycles with out_ready=1 -> one cycle later out_data=0x11223344, out_mask=4'b1111, out_last=0, out_valid=1 for 1 cycle.
- Bytes 0xAA,0xBB with in_last on 0xBB -> out_data=0xAABB0000, out_mask=4'b1100, out_last=1.
- Single byte 0x5A with in_last -> out_data=0x5A000000, out_mask=4'b1000, out_last=1; the next word starts at lane 0.
- Full word emitted with out_ready=0 for 5 cycles -> outputs stable, in_ready=0 (base) for all 5 cycles; transfer on release.
- Reset asserted after 2 of 4 bytes, then 0x01..0x04 -> out_data=0x01020304, with no residue from the discarded bytes.
- With BYTE_LANE_PACKER_DOUBLE_BUFFER_EN and continuous input, out_ready=1 -> words emitted every 4 cycles, in_ready constantly 1.
